// File: rtl/cpc_io_initiator.sv
// cpc_io_initiator
// Turns single-cycle host requests into Z80-style IORQ read/write bus cycles
// on the CPC expansion port. An OUT cycle can optionally poll the status port
// at the same address until READY_BIT equals READY_LEVEL before writing.
//
// Ports:
//   i_CLK, i_RESET          clock, synchronous active-high reset
//   i_REQ                   request strobe, accepted only while idle
//   i_REQ_WR/i_REQ_POLL     1 = OUT cycle / poll status before the OUT
//   i_REQ_ADR, i_REQ_DATA   port address, write data
//   o_BUSY, o_DONE, o_ERR   busy level, completion pulse, poll timeout
//   o_RD_DATA               last sampled read or status byte
//   oADR, ioCPC_DATA        bus address, bidirectional bus data
//   o_IORQ, o_RD, o_WR      active-low bus strobes
module cpc_io_initiator #(
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_STROBE    = 3,
  parameter int unsigned T_HOLD      = 1,
  parameter int unsigned POLL_MAX    = 255,
  parameter int unsigned READY_BIT   = 7,
  parameter bit          READY_LEVEL = 1'b0
) (
  input  logic        i_CLK,
  input  logic        i_RESET,
  input  logic        i_REQ,
  input  logic        i_REQ_WR,
  input  logic        i_REQ_POLL,
  input  logic [15:0] i_REQ_ADR,
  input  logic [7:0]  i_REQ_DATA,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic        o_ERR,
  output logic [7:0]  o_RD_DATA,
  output logic [15:0] oADR,
  inout  wire  [7:0]  ioCPC_DATA,
  output logic        o_IORQ,
  output logic        o_RD,
  output logic        o_WR
);

  localparam int unsigned T_MAX =
    (T_SETUP > T_STROBE) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                         : ((T_STROBE > T_HOLD) ? T_STROBE : T_HOLD);
  // Phase counter only ever holds T_x-1.
  localparam int unsigned CW = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [3:0] {
    IDLE, P_SETUP, P_STROBE, P_HOLD, P_CHECK, SETUP, STROBE, HOLD, DONE
  } state_t;

  state_t         state, state_n;
  logic [CW-1:0]  phase;
  logic [7:0]     poll_cnt;
  logic           wr_q, err_q;
  logic [15:0]    adr_q;
  logic [7:0]     data_q, rd_data_q;

  logic           accept, timeout, poll_again, last, ready, sample, drive_data;

  function automatic logic [CW-1:0] phase_load(input state_t s);
    case (s)
      SETUP,  P_SETUP:  return CW'(T_SETUP - 1);
      STROBE, P_STROBE: return CW'(T_STROBE - 1);
      HOLD,   P_HOLD:   return CW'(T_HOLD - 1);
      default:          return '0;
    endcase
  endfunction

  assign last  = (phase == '0);
  assign ready = (rd_data_q[READY_BIT] == READY_LEVEL);

  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    timeout    = 1'b0;
    poll_again = 1'b0;
    case (state)
      IDLE:
        if (i_REQ) begin
          accept  = 1'b1;
          state_n = (i_REQ_WR && i_REQ_POLL) ? P_SETUP : SETUP;
        end
      P_SETUP:  if (last) state_n = P_STROBE;
      P_STROBE: if (last) state_n = P_HOLD;
      P_HOLD:   if (last) state_n = P_CHECK;
      P_CHECK:
        if (ready) begin
          state_n = SETUP;
        end else if (({1'b0, poll_cnt} + 9'd1) < 9'(POLL_MAX)) begin
          poll_again = 1'b1;
          state_n    = P_SETUP;
        end else begin
          timeout = 1'b1;
          state_n = DONE;
        end
      SETUP:    if (last) state_n = STROBE;
      STROBE:   if (last) state_n = HOLD;
      HOLD:     if (last) state_n = DONE;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Status polls are always reads; the main cycle follows the latched direction.
  always_comb begin
    o_IORQ     = !(state == STROBE || state == P_STROBE);
    o_RD       = !((state == STROBE && !wr_q) || state == P_STROBE);
    o_WR       = !(state == STROBE && wr_q);
    drive_data = wr_q && (state == SETUP || state == STROBE || state == HOLD);
    sample     = ((state == STROBE && !wr_q) || state == P_STROBE) && last;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state     <= IDLE;
      phase     <= '0;
      poll_cnt  <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      adr_q     <= '0;
      data_q    <= '0;
      rd_data_q <= '0;
    end else begin
      state <= state_n;
      if (state_n != state) phase <= phase_load(state_n);
      else if (!last)       phase <= phase - CW'(1);

      if (accept) begin
        wr_q     <= i_REQ_WR;
        adr_q    <= i_REQ_ADR;
        data_q   <= i_REQ_DATA;
        poll_cnt <= '0;
        err_q    <= 1'b0;
      end
      if (poll_again && poll_cnt != '1) poll_cnt <= poll_cnt + 8'd1;
      if (timeout) err_q <= 1'b1;
      if (sample)  rd_data_q <= ioCPC_DATA;
    end
  end

  // The address register simply holds the last request between transactions,
  // so oADR can only change on an acceptance edge, never under a strobe.
  assign oADR       = adr_q;
  assign ioCPC_DATA = drive_data ? data_q : 8'bz;
  assign o_RD_DATA  = rd_data_q;
  assign o_BUSY     = (state != IDLE);
  assign o_DONE     = (state == DONE);
  assign o_ERR      = (state == DONE) && err_q;

endmodule

// File: tb/tb_cpc_io_initiator.sv
// Testbench for cpc_io_initiator: two instances (defaults, and POLL_MAX=3),
// each with a pulled-up data bus and a bench device that answers read strobes.
// Expected per-cycle behaviour comes from a timeline model built from the
// setup/strobe/hold durations and the list of status bytes the device returns.
module tb_cpc_io_initiator;
  localparam int unsigned TS = 2, TST = 3, TH = 1;
  localparam int unsigned P  = TS + TST + TH + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_a, req_b, req_wr, req_poll;
  logic [15:0] req_adr;
  logic [7:0]  req_data, dev_data;

  logic        busy_a, done_a, err_a, iorq_a, rd_a, wr_a;
  logic        busy_b, done_b, err_b, iorq_b, rd_b, wr_b;
  logic [7:0]  rdd_a, rdd_b;
  logic [15:0] adr_a, adr_b;
  wire  [7:0]  bus_a, bus_b;

  assign bus_a = (!iorq_a && !rd_a) ? dev_data : 8'bz;
  assign bus_b = (!iorq_b && !rd_b) ? dev_data : 8'bz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (bus_a[g]);
    pullup (bus_b[g]);
  end

  cpc_io_initiator u_dut (
    .i_CLK(clk), .i_RESET(rst), .i_REQ(req_a), .i_REQ_WR(req_wr),
    .i_REQ_POLL(req_poll), .i_REQ_ADR(req_adr), .i_REQ_DATA(req_data),
    .o_BUSY(busy_a), .o_DONE(done_a), .o_ERR(err_a), .o_RD_DATA(rdd_a),
    .oADR(adr_a), .ioCPC_DATA(bus_a), .o_IORQ(iorq_a), .o_RD(rd_a), .o_WR(wr_a)
  );

  cpc_io_initiator #(.POLL_MAX(3)) u_dut_pm3 (
    .i_CLK(clk), .i_RESET(rst), .i_REQ(req_b), .i_REQ_WR(req_wr),
    .i_REQ_POLL(req_poll), .i_REQ_ADR(req_adr), .i_REQ_DATA(req_data),
    .o_BUSY(busy_b), .o_DONE(done_b), .o_ERR(err_b), .o_RD_DATA(rdd_b),
    .oADR(adr_b), .ioCPC_DATA(bus_b), .o_IORQ(iorq_b), .o_RD(rd_b), .o_WR(wr_b)
  );

  logic sel;
  wire [4:0]  ctl_a = {iorq_a, rd_a, wr_a, busy_a, done_a};
  wire [4:0]  ctl_b = {iorq_b, rd_b, wr_b, busy_b, done_b};
  wire [4:0]  ctl_s = sel ? ctl_b : ctl_a;
  wire [7:0]  bus_s = sel ? bus_b : bus_a;
  wire [15:0] adr_s = sel ? adr_b : adr_a;
  wire [7:0]  rdd_s = sel ? rdd_b : rdd_a;
  wire        err_s = sel ? err_b : err_a;

  int checks = 0, errors = 0;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ctl_a, ctl_b} !== {5'b11100, 5'b11100}) begin
      errors++; $display("FAIL reset_ctl got %b want %b", {ctl_a, ctl_b}, {5'b11100, 5'b11100});
    end
    checks++;
    if ({adr_a, adr_b, rdd_a, rdd_b} !== 48'h0) begin
      errors++; $display("FAIL reset_regs got %h want 0", {adr_a, adr_b, rdd_a, rdd_b});
    end
    checks++;
    if ({bus_a, bus_b, err_a, err_b} !== {16'hFFFF, 2'b00}) begin
      errors++; $display("FAIL reset_bus got %h/%h err %b%b want ffff err 00", bus_a, bus_b, err_a, err_b);
    end
    rst = 1'b0;
  endtask

  // One complete transaction, checked cycle by cycle from the acceptance edge.
  task automatic test_txn(input string name, input logic use_b, input logic wr,
                          input logic poll, input logic [15:0] adr, input logic [7:0] data,
                          input logic [7:0] stat[$], input int unsigned pm);
    int unsigned n_polls, done_c, idx, off, k, sz;
    bit          issue, strobe, active, chk_bus, prev_rd;
    logic [4:0]  e_ctl;
    logic [7:0]  e_bus, sv;
    sz      = stat.size();
    n_polls = 0;
    issue   = 1'b1;
    if (wr && poll) begin
      issue = 1'b0;
      for (int unsigned i = 0; i < pm; i++) begin
        n_polls++;
        sv = stat[(i < sz) ? i : sz - 1];
        if (sv[7] == 1'b0) begin issue = 1'b1; break; end
      end
    end
    done_c = n_polls * P + (issue ? (TS + TST + TH + 1) : 1);

    @(negedge clk);
    sel = use_b; req_wr = wr; req_poll = poll; req_adr = adr; req_data = data;
    idx = 0; dev_data = stat[0];
    if (use_b) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk);
    #1;
    req_a = 1'b0; req_b = 1'b0;
    prev_rd = 1'b1;

    for (int unsigned c = 1; c <= done_c + 1; c++) begin
      @(negedge clk);
      chk_bus = 1'b1; e_bus = 8'hFF; active = 1'b0; strobe = 1'b0;
      if (c <= n_polls * P) begin
        off    = (c - 1) % P + 1;
        k      = (c - 1) / P;
        strobe = (off > TS) && (off <= TS + TST);
        active = (off <= TS + TST + TH);
        e_ctl  = {!strobe, !strobe, 1'b1, 1'b1, 1'b0};
        if (strobe) chk_bus = 1'b0;
        if (off == P) begin
          sv = stat[(k < sz) ? k : sz - 1];
          checks++;
          if (rdd_s !== sv) begin
            errors++; $display("FAIL %s status c=%0d got %h want %h", name, c, rdd_s, sv);
          end
        end
      end else if (c < done_c) begin
        off    = c - n_polls * P;
        strobe = (off > TS) && (off <= TS + TST);
        active = 1'b1;
        e_ctl  = {!strobe, !(strobe && !wr), !(strobe && wr), 1'b1, 1'b0};
        if (wr) e_bus = data;
        else if (strobe) chk_bus = 1'b0;
        if (!wr && off == TS + TST + 1) begin
          checks++;
          if (rdd_s !== stat[0]) begin
            errors++; $display("FAIL %s rd_data c=%0d got %h want %h", name, c, rdd_s, stat[0]);
          end
        end
      end else if (c == done_c) begin
        e_ctl = 5'b11111;
        checks++;
        if (err_s !== !issue) begin
          errors++; $display("FAIL %s err got %b want %b", name, err_s, !issue);
        end
      end else begin
        e_ctl = 5'b11100;
      end

      checks++;
      if (ctl_s !== e_ctl) begin
        errors++; $display("FAIL %s ctl c=%0d got %b want %b (iorq rd wr busy done)", name, c, ctl_s, e_ctl);
      end
      if (chk_bus) begin
        checks++;
        if (bus_s !== e_bus) begin
          errors++; $display("FAIL %s bus c=%0d got %h want %h", name, c, bus_s, e_bus);
        end
      end
      if (active) begin
        checks++;
        if (adr_s !== adr) begin
          errors++; $display("FAIL %s adr c=%0d got %h want %h", name, c, adr_s, adr);
        end
      end
      // Device moves to the next status byte once a read strobe ends.
      if (!prev_rd && ctl_s[3]) begin
        idx++;
        dev_data = stat[(idx < sz) ? idx : sz - 1];
      end
      prev_rd = ctl_s[3];
    end
  endtask

  task automatic test_back_to_back();
    int unsigned wr_lows, dones;
    wr_lows = 0; dones = 0;
    @(negedge clk);
    sel = 1'b0; req_wr = 1'b1; req_poll = 1'b0; req_adr = 16'hFAEE; req_data = 8'h5A;
    req_a = 1'b1;
    @(posedge clk);
    for (int unsigned c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (!wr_a) wr_lows++;
      if (done_a) dones++;
      if (c == 7 || c == 15) begin
        checks++;
        if (done_a !== 1'b1) begin
          errors++; $display("FAIL b2b done c=%0d got %b want 1", c, done_a);
        end
      end
      if (c == 8 || c == 9 || c == 16 || c == 17) begin
        checks++;
        if (busy_a !== (c == 9)) begin
          errors++; $display("FAIL b2b busy c=%0d got %b want %b", c, busy_a, (c == 9));
        end
      end
      if (c == 10) req_a = 1'b0;
    end
    checks++;
    if (wr_lows != 2 * TST || dones != 2) begin
      errors++; $display("FAIL b2b counts wr_low %0d done %0d want %0d and 2", wr_lows, dones, 2 * TST);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  q[$];
    int unsigned bad;
    bad = 0;
    @(negedge clk);
    sel = 1'b0; req_wr = 1'b1; req_poll = 1'b0; req_adr = 16'hFBEE; req_data = 8'hC3;
    req_a = 1'b1;
    @(posedge clk);
    #1 req_a = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({iorq_a, wr_a} !== 2'b00) begin
      errors++; $display("FAIL rstmid strobe got %b want 00", {iorq_a, wr_a});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ctl_a, bus_a, adr_a} !== {5'b11100, 8'hFF, 16'h0000}) begin
      errors++; $display("FAIL rstmid after got %b %h %h want 11100 ff 0000", ctl_a, bus_a, adr_a);
    end
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done_a || busy_a) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rstmid idle got %0d active cycles want 0", bad);
    end
    q.push_back(8'h42);
    test_txn("rstmid_read", 1'b0, 1'b0, 1'b0, 16'hFFAB, 8'h99, q, 255);
  endtask

  task automatic test_random();
    logic [7:0]  q[$];
    logic [7:0]  v;
    int unsigned n;
    logic        use_b;
    for (int unsigned t = 0; t < 18; t++) begin
      use_b = (t >= 12);
      q.delete();
      n = $urandom_range(1, 4);
      for (int unsigned i = 0; i < n; i++) begin
        v = 8'($urandom);
        if (!use_b && i == n - 1) v[7] = 1'b0;
        q.push_back(v);
      end
      test_txn("random", use_b, 1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom),
               q, use_b ? 3 : 255);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; req_wr = 1'b0; req_poll = 1'b0;
    req_adr = '0; req_data = '0; dev_data = '0; sel = 1'b0;
    test_reset();
    q.delete(); q.push_back(8'h00);
    test_txn("write", 1'b0, 1'b1, 1'b0, 16'hFBEE, 8'hA5, q, 255);
    q.delete(); q.push_back(8'h3C);
    test_txn("read", 1'b0, 1'b0, 1'b0, 16'hFBFE, 8'h77, q, 255);
    q.delete(); q.push_back(8'h80); q.push_back(8'h80); q.push_back(8'h00);
    test_txn("polled_write", 1'b0, 1'b1, 1'b1, 16'hFBEE, 8'h11, q, 255);
    q.delete(); q.push_back(8'h80);
    test_txn("poll_timeout", 1'b1, 1'b1, 1'b1, 16'hFBEE, 8'h22, q, 3);
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
